// File: rtl/sdram_client_arbiter.sv
// N-client arbiter in front of SDRAMBus: registered grant, per-client request mux and
// finished routing, fixed-priority or round-robin selection, lock bursts and a completion timeout.
module sdram_client_arbiter #(
  parameter int NUM_CLIENTS = 5,
  parameter int ADDR_W      = 23,
  parameter int DATA_W      = 16,
  parameter int ARB_MODE    = 1,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic [NUM_CLIENTS-1:0]        cli_read,
  input  logic [NUM_CLIENTS-1:0]        cli_write,
  input  logic [NUM_CLIENTS-1:0]        cli_lock,
  input  logic [NUM_CLIENTS*ADDR_W-1:0] cli_addr,
  input  logic [NUM_CLIENTS*DATA_W-1:0] cli_writedata,
  output logic [DATA_W-1:0]             cli_readdata,
  output logic [NUM_CLIENTS-1:0]        cli_finished,
  output logic [NUM_CLIENTS-1:0]        grant,
  output logic                          timeout_err,
  output logic                          sdram_read,
  output logic                          sdram_write,
  output logic [ADDR_W-1:0]             sdram_addr,
  output logic [DATA_W-1:0]             sdram_writedata,
  input  logic [DATA_W-1:0]             sdram_readdata,
  input  logic                          sdram_finished
);
  localparam int IW = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;
  localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state, state_nxt;

  logic [NUM_CLIENTS-1:0] req;
  logic [IW-1:0]          ptr, owner, winner, sel;
  logic [TW-1:0]          timer;
  logic                   found, relock, expire;
  logic                   issue_new, issue, complete, abort, retire, count, drop_grant;

  assign req    = cli_read | cli_write;
  assign relock = cli_lock[owner] & req[owner];
  assign expire = (TIMEOUT_CYC != 0) && (timer == TW'(TIMEOUT_CYC - 1));
  assign sel    = (state == IDLE) ? winner : owner;

  // First requester at or after the search base, wrapping; base is 0 in fixed mode.
  always_comb begin
    int j;
    j      = 0;
    winner = '0;
    found  = 1'b0;
    for (int i = 0; i < NUM_CLIENTS; i++) begin
      j = ((ARB_MODE == 1) ? int'(ptr) : 0) + i;
      if (j >= NUM_CLIENTS) j = j - NUM_CLIENTS;
      if (!found && req[j]) begin
        found  = 1'b1;
        winner = IW'(j);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (found) state_nxt = BUSY;
      BUSY:    if (sdram_finished || expire) state_nxt = DONE;
      DONE:    state_nxt = relock ? BUSY : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    issue_new  = (state == IDLE) && found;
    issue      = issue_new || ((state == DONE) && relock);
    complete   = (state == BUSY) && sdram_finished;
    abort      = (state == BUSY) && !sdram_finished && expire;
    retire     = complete || abort;
    count      = (state == BUSY) && !retire;
    drop_grant = (state == DONE) && !relock;
  end

  // Read wins when a client raises both; its write stays pending for a later grant.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      grant           <= '0;
      owner           <= '0;
      ptr             <= '0;
      timer           <= '0;
      cli_finished    <= '0;
      cli_readdata    <= '0;
      timeout_err     <= 1'b0;
      sdram_read      <= 1'b0;
      sdram_write     <= 1'b0;
      sdram_addr      <= '0;
      sdram_writedata <= '0;
    end else begin
      cli_finished <= '0;
      if (issue) begin
        owner           <= sel;
        grant           <= NUM_CLIENTS'(1) << sel;
        sdram_read      <= cli_read[sel];
        sdram_write     <= cli_write[sel] & ~cli_read[sel];
        sdram_addr      <= cli_addr[sel*ADDR_W +: ADDR_W];
        sdram_writedata <= cli_writedata[sel*DATA_W +: DATA_W];
        timer           <= '0;
      end
      if (issue_new) ptr <= (winner == IW'(NUM_CLIENTS - 1)) ? '0 : winner + IW'(1);
      if (count) timer <= timer + TW'(1);
      if (retire) begin
        sdram_read   <= 1'b0;
        sdram_write  <= 1'b0;
        cli_finished <= grant;
        cli_readdata <= complete ? sdram_readdata : '0;
        if (abort) timeout_err <= 1'b1;
      end
      if (drop_grant) grant <= '0;
    end
  end
endmodule

// File: tb/tb_sdram_client_arbiter.sv
// Bench for sdram_client_arbiter: round-robin DUT under full check, fixed-priority DUT
// on the same client inputs, table of single transactions plus multi-cycle sequences.
module tb_sdram_client_arbiter;
  localparam int N = 5, AW = 23, DW = 16, TO = 16;

  logic clk = 1'b0, rst = 1'b1;
  logic [N-1:0]    cli_read = '0, cli_write = '0, cli_lock = '0;
  logic [N*AW-1:0] cli_addr = '0;
  logic [N*DW-1:0] cli_wdata = '0;
  logic [DW-1:0]   resp_data = '0;
  logic [1:0]      fin = '0;
  int              lat = 5;
  bit              resp_en = 1'b1;
  bit              fix_chk = 1'b0;
  int              fix_issues = 0;
  int              checks = 0, errors = 0;

  wire  [1:0]    s_rd, s_wr;
  logic [DW-1:0] cli_readdata, f_rdata, sdram_wdata, f_wdata;
  logic [N-1:0]  cli_finished, grant, f_fin, f_grant;
  logic          timeout_err, f_terr;
  logic [AW-1:0] sdram_addr, f_addr;

  typedef struct { logic [N-1:0] gnt; logic rd; logic [AW-1:0] addr; logic [DW-1:0] wd; } iss_t;
  typedef struct { logic [N-1:0] fin; logic rd; logic [DW-1:0] rdata; } cmp_t;
  typedef struct {
    int cli; logic rd; logic wr; logic [AW-1:0] addr; logic [DW-1:0] wd; logic [DW-1:0] rdata;
    int lat; logic [N-1:0] exp_gnt; logic exp_rd; logic [DW-1:0] exp_rdata;
  } vec_t;

  iss_t iss_q[$];
  cmp_t cmp_q[$];

  sdram_client_arbiter #(.NUM_CLIENTS(N), .ADDR_W(AW), .DATA_W(DW), .ARB_MODE(1), .TIMEOUT_CYC(TO)) dut (
    .i_clk(clk), .i_rst(rst), .cli_read(cli_read), .cli_write(cli_write), .cli_lock(cli_lock),
    .cli_addr(cli_addr), .cli_writedata(cli_wdata), .cli_readdata(cli_readdata),
    .cli_finished(cli_finished), .grant(grant), .timeout_err(timeout_err),
    .sdram_read(s_rd[0]), .sdram_write(s_wr[0]), .sdram_addr(sdram_addr),
    .sdram_writedata(sdram_wdata), .sdram_readdata(resp_data), .sdram_finished(fin[0]));

  sdram_client_arbiter #(.NUM_CLIENTS(N), .ADDR_W(AW), .DATA_W(DW), .ARB_MODE(0), .TIMEOUT_CYC(TO)) dut_fix (
    .i_clk(clk), .i_rst(rst), .cli_read(cli_read), .cli_write(cli_write), .cli_lock(cli_lock),
    .cli_addr(cli_addr), .cli_writedata(cli_wdata), .cli_readdata(f_rdata),
    .cli_finished(f_fin), .grant(f_grant), .timeout_err(f_terr),
    .sdram_read(s_rd[1]), .sdram_write(s_wr[1]), .sdram_addr(f_addr),
    .sdram_writedata(f_wdata), .sdram_readdata(resp_data), .sdram_finished(fin[1]));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_txn(input int c, input logic rd, input logic [DW-1:0] rdata, input bit fin_exp);
    iss_t ie;
    cmp_t ce;
    ie.gnt  = N'(1) << c;
    ie.rd   = rd;
    ie.addr = cli_addr[c*AW +: AW];
    ie.wd   = cli_wdata[c*DW +: DW];
    iss_q.push_back(ie);
    if (fin_exp) begin
      ce.fin = ie.gnt; ce.rd = rd; ce.rdata = rdata;
      cmp_q.push_back(ce);
    end
  endtask

  task automatic wait_fin();
    int n = 0;
    do begin @(negedge clk); n++; end while (cli_finished == '0 && n < 200);
    if (cli_finished == '0) begin
      checks++; errors++;
      $display("FAIL wait_fin: no cli_finished within 200 cycles (t=%0t)", $time);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // SDRAMBus model: finished pulse after `lat` cycles of a held request, one per DUT.
  initial begin
    int cnt[2] = '{0, 0};
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        if (fin[d]) begin
          fin[d] = 1'b0; cnt[d] = 0;
        end else if (resp_en && (s_rd[d] || s_wr[d])) begin
          cnt[d]++;
          if (cnt[d] == lat) fin[d] = 1'b1;
        end else cnt[d] = 0;
      end
    end
  end

  // Scoreboard: each new SDRAM request and each finished pulse is matched against the queues.
  initial begin
    bit prev = 1'b0, fprev = 1'b0;
    iss_t ie;
    cmp_t ce;
    forever begin
      @(negedge clk);
      if (!rst) begin
        chk("grant_onehot0", 32'($onehot0(grant)), 1);
        chk("fin_onehot0", 32'($onehot0(cli_finished)), 1);
        if ((s_rd[0] || s_wr[0]) && !prev) begin
          if (iss_q.size() == 0) chk("unexpected_issue", grant, 0);
          else begin
            ie = iss_q.pop_front();
            chk("iss_grant", grant, ie.gnt);
            chk("iss_read", s_rd[0], ie.rd);
            chk("iss_write", s_wr[0], !ie.rd);
            chk("iss_addr", sdram_addr, ie.addr);
            if (!ie.rd) chk("iss_wdata", sdram_wdata, ie.wd);
          end
        end
        if (cli_finished != '0) begin
          chk("fin_sdram_released", s_rd[0] | s_wr[0], 0);
          if (cmp_q.size() == 0) chk("unexpected_fin", cli_finished, 0);
          else begin
            ce = cmp_q.pop_front();
            chk("fin_owner", cli_finished, ce.fin);
            if (ce.rd) chk("fin_rdata", cli_readdata, ce.rdata);
          end
        end
        if (fix_chk && (s_rd[1] || s_wr[1]) && !fprev) begin
          fix_issues++;
          chk("fix_grant", f_grant, 5'b00001);
        end
      end
      prev  = s_rd[0] || s_wr[0];
      fprev = s_rd[1] || s_wr[1];
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vec[5];
    int n;
    int ord[6];
    logic [N-1:0] seen;
    // cli, rd, wr, addr, wdata, sdram rdata, latency | grant, sdram op is read, cli_readdata
    vec[0] = '{2, 1'b1, 1'b0, 23'h000123, 16'h0000, 16'hBEEF, 5,  5'b00100, 1'b1, 16'hBEEF};
    vec[1] = '{0, 1'b0, 1'b1, 23'h7FFFFF, 16'h1234, 16'h0000, 1,  5'b00001, 1'b0, 16'h0000};
    vec[2] = '{4, 1'b1, 1'b0, 23'h400000, 16'h0000, 16'h0001, 3,  5'b10000, 1'b1, 16'h0001};
    vec[3] = '{3, 1'b1, 1'b0, 23'h000000, 16'h0000, 16'hFFFF, TO, 5'b01000, 1'b1, 16'hFFFF};
    vec[4] = '{1, 1'b0, 1'b1, 23'h2AAAAA, 16'hA5A5, 16'h0000, 2,  5'b00010, 1'b0, 16'h0000};
    ord = '{0, 1, 4, 0, 1, 4};
    for (int k = 0; k < N; k++) begin
      cli_addr[k*AW +: AW]  = 23'h010000 + AW'(k);
      cli_wdata[k*DW +: DW] = 16'hD000 + DW'(k);
    end

    repeat (3) @(negedge clk);
    chk("rst_grant", grant, 0);
    chk("rst_fin", cli_finished, 0);
    chk("rst_sdram_rw", {s_rd[0], s_wr[0]}, 0);
    chk("rst_terr", timeout_err, 0);
    chk("rst_rdata", cli_readdata, 0);
    chk("rst_addr", sdram_addr, 0);
    rst = 1'b0;

    foreach (vec[i]) begin
      lat = vec[i].lat;
      resp_data = vec[i].rdata;
      @(negedge clk);
      cli_addr[vec[i].cli*AW +: AW]  = vec[i].addr;
      cli_wdata[vec[i].cli*DW +: DW] = vec[i].wd;
      cli_read[vec[i].cli]  = vec[i].rd;
      cli_write[vec[i].cli] = vec[i].wr;
      iss_q.push_back('{vec[i].exp_gnt, vec[i].exp_rd, vec[i].addr, vec[i].wd});
      cmp_q.push_back('{vec[i].exp_gnt, vec[i].exp_rd, vec[i].exp_rdata});
      n = 0;
      do begin @(negedge clk); n++; end while (cli_finished == '0 && n < 200);
      chk("vec_fin_latency", n, vec[i].lat + 1);
      cli_read = '0; cli_write = '0;
      chk("vec_no_timeout", timeout_err, 0);
      @(negedge clk);
      chk("vec_grant_released", grant, 0);
    end

    // Round-robin fairness with three continuous writers; fixed DUT must serve only client 0.
    do_reset();
    lat = 2;
    fix_chk = 1'b1;
    foreach (ord[i]) push_txn(ord[i], 1'b0, '0, 1'b1);
    cli_write = 5'b10011;
    repeat (6) wait_fin();
    cli_write = '0;
    fix_chk = 1'b0;
    chk("fix_issued", 32'(fix_issues >= 2), 1);

    // Locked burst of four reads by client 3 while client 0 waits.
    do_reset();
    lat = 2;
    resp_data = 16'h3C3C;
    cli_addr[3*AW +: AW] = 23'h300000;
    cli_lock[3] = 1'b1;
    cli_read[3] = 1'b1;
    push_txn(3, 1'b1, 16'h3C3C, 1'b1);
    @(negedge clk);
    cli_read[0] = 1'b1;
    for (int b = 0; b < 4; b++) begin
      wait_fin();
      if (b < 3) begin
        cli_addr[3*AW +: AW] = 23'h300001 + AW'(b);
        push_txn(3, 1'b1, 16'h3C3C, 1'b1);
        @(negedge clk);
        chk("lock_gap", s_rd[0], 1);
      end else begin
        cli_read[3] = 1'b0;
        cli_lock[3] = 1'b0;
        push_txn(0, 1'b1, 16'h3C3C, 1'b1);
      end
    end
    wait_fin();
    cli_read[0] = 1'b0;

    // Read and write raised together: read first, write on the following grant.
    lat = 2;
    resp_data = 16'h2468;
    push_txn(1, 1'b1, 16'h2468, 1'b1);
    push_txn(1, 1'b0, '0, 1'b1);
    @(negedge clk);
    cli_read[1] = 1'b1;
    cli_write[1] = 1'b1;
    wait_fin();
    cli_read[1] = 1'b0;
    wait_fin();
    cli_write[1] = 1'b0;

    // Timeout: request held for TO cycles, then aborted with zero read data and sticky error.
    chk("to_err_before", timeout_err, 0);
    resp_en = 1'b0;
    @(negedge clk);
    cli_read[2] = 1'b1;
    push_txn(2, 1'b1, 16'h0000, 1'b1);
    n = 0;
    do begin @(negedge clk); n++; end while (cli_finished == '0 && n < 100);
    chk("to_fin_latency", n, TO + 1);
    chk("to_err_set", timeout_err, 1);
    chk("to_rdata_zero", cli_readdata, 0);
    cli_read[2] = 1'b0;
    resp_en = 1'b1;
    lat = 3;
    resp_data = 16'h7777;
    @(negedge clk);
    cli_read[0] = 1'b1;
    push_txn(0, 1'b1, 16'h7777, 1'b1);
    wait_fin();
    cli_read[0] = 1'b0;
    chk("to_err_sticky", timeout_err, 1);

    // Reset in the third BUSY cycle abandons the transaction silently.
    resp_en = 1'b0;
    @(negedge clk);
    cli_read[4] = 1'b1;
    push_txn(4, 1'b1, '0, 1'b0);
    repeat (3) @(negedge clk);
    chk("midrst_busy", s_rd[0], 1);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_grant", grant, 0);
    chk("midrst_sdram_rw", {s_rd[0], s_wr[0]}, 0);
    chk("midrst_fin", cli_finished, 0);
    chk("midrst_terr", timeout_err, 0);
    chk("midrst_rdata", cli_readdata, 0);
    chk("midrst_addr", sdram_addr, 0);
    rst = 1'b0;
    cli_read[4] = 1'b0;
    resp_en = 1'b1;
    seen = '0;
    repeat (20) begin @(negedge clk); seen |= cli_finished; end
    chk("midrst_no_fin", seen, 0);

    chk("iss_q_drained", iss_q.size(), 0);
    chk("cmp_q_drained", cmp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
